gat_bram_port_adapter: RTL and testbench

GAT_BRAM_PORT_ADAPTER -- requirements
Module: gat_bram_port_adapter

---
 rtl/gat_pkg.sv | 25 ++
 rtl/gat_wr_channel.sv | 73 +++++++
 rtl/gat_bram_port_adapter.sv | 169 ++++++++++++++++
 tb/tb_gat_bram_port_adapter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM port adapter: FSM encoding, error bit
// positions and the legal read-latency range.
package gat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } gat_state_e;

  localparam int unsigned ERR_MISALIGN    = 0;
  localparam int unsigned ERR_NOT_LOADING = 1;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // core_ready is ignored until the core has been running this many cycles
  localparam int unsigned RUN_MIN_AGE = 2;

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/gat_wr_channel.sv
// One host write channel: alignment check, one register stage towards the
// core BRAM port, and a saturating accepted-write counter.
module gat_wr_channel #(
  parameter int unsigned TOP_WIDTH = 32,
  parameter int unsigned ADDR_W    = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_ena,
  input  logic                 wr_wea,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [TOP_WIDTH-1:0] wr_din,
  input  logic                 allow,
  input  logic                 cnt_clr,
  output logic                 accept,
  output logic                 misaligned,
  output logic                 core_ena,
  output logic                 core_wea,
  output logic [ADDR_W-3:0]    core_addra,
  output logic [TOP_WIDTH-1:0] core_din,
  output logic [ADDR_W-1:0]    wr_cnt
);

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  logic                 req;
  logic                 ena_q, ena_d;
  logic [ADDR_W-3:0]    addra_q, addra_d;
  logic [TOP_WIDTH-1:0] din_q, din_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]    cnt_base;

  assign req        = wr_ena & wr_wea;
  assign misaligned = req & (wr_addr[1:0] != 2'b00);
  assign accept     = req & ~misaligned & allow;

  always_comb begin
    ena_d   = accept;
    addra_d = addra_q;
    din_d   = din_q;
    if (accept) begin
      addra_d = wr_addr[ADDR_W-1:2];
      din_d   = wr_din;
    end
    // A clear and an accept in the same cycle leave the count at one
    cnt_base = cnt_clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (accept && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ena_q   <= 1'b0;
      addra_q <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ena_q   <= ena_d;
      addra_q <= addra_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_ena   = ena_q;
  assign core_wea   = ena_q;
  assign core_addra = addra_q;
  assign core_din   = din_q;
  assign wr_cnt     = cnt_q;

endmodule

// File: rtl/gat_bram_port_adapter.sv
// Host-to-core BRAM port adapter for the GAT accelerator: per-channel write
// staging, load/run/done sequencing and a pipelined feature read-back path.
module gat_bram_port_adapter
  import gat_pkg::*;
#(
  parameter int unsigned TOP_WIDTH  = 32,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             wr_ena,
  input  logic [NUM_CH-1:0]             wr_wea,
  input  logic [NUM_CH*ADDR_W-1:0]      wr_addra,
  input  logic [NUM_CH*TOP_WIDTH-1:0]   wr_din,
  input  logic [NUM_CH-1:0]             load_done_in,
  input  logic                          layer_in,
  input  logic                          core_ready,
  output logic [NUM_CH-1:0]             core_ena,
  output logic [NUM_CH-1:0]             core_wea,
  output logic [NUM_CH*(ADDR_W-2)-1:0]  core_addra,
  output logic [NUM_CH*TOP_WIDTH-1:0]   core_din,
  output logic [NUM_CH-1:0]             core_load_done,
  output logic                          core_layer,
  output logic                          core_start,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [ADDR_W-3:0]             core_rd_addr,
  input  logic [TOP_WIDTH-1:0]          core_rd_dout,
  output logic                          rd_valid,
  output logic [TOP_WIDTH-1:0]          rd_data,
  output logic [1:0]                    state_o,
  output logic [1:0]                    err_o,
  output logic [NUM_CH*ADDR_W-1:0]      wr_cnt
);

  localparam int unsigned AW2 = ADDR_W - 2;

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
    $error("gat_bram_port_adapter: RD_LATENCY out of range");
  end

  gat_state_e          state_q, state_d;
  logic [1:0]          age_q, age_d;
  logic                start_q, start_d;
  logic                layer_q, layer_d;
  logic [NUM_CH-1:0]   ld_q, ld_d;
  logic [1:0]          err_q, err_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

  logic [NUM_CH-1:0]   wr_req;
  logic [NUM_CH-1:0]   ch_accept;
  logic [NUM_CH-1:0]   ch_misaligned;
  logic                allow;
  logic                cnt_clr;
  logic                rd_addr_unused;

  assign wr_req  = wr_ena & wr_wea;
  assign allow   = (state_q != ST_RUN);
  assign cnt_clr = (state_q == ST_DONE) && (|ch_accept);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    gat_wr_channel #(
      .TOP_WIDTH (TOP_WIDTH),
      .ADDR_W    (ADDR_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_ena     (wr_ena[k]),
      .wr_wea     (wr_wea[k]),
      .wr_addr    (wr_addra[k*ADDR_W +: ADDR_W]),
      .wr_din     (wr_din[k*TOP_WIDTH +: TOP_WIDTH]),
      .allow      (allow),
      .cnt_clr    (cnt_clr),
      .accept     (ch_accept[k]),
      .misaligned (ch_misaligned[k]),
      .core_ena   (core_ena[k]),
      .core_wea   (core_wea[k]),
      .core_addra (core_addra[k*AW2 +: AW2]),
      .core_din   (core_din[k*TOP_WIDTH +: TOP_WIDTH]),
      .wr_cnt     (wr_cnt[k*ADDR_W +: ADDR_W])
    );
  end

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    start_d = 1'b0;
    layer_d = layer_q;
    err_d   = err_q;

    ld_d = ld_q;
    if (cnt_clr) begin
      ld_d = '0;
    end else if ((state_q == ST_IDLE) || (state_q == ST_LOADING)) begin
      ld_d = ld_q | load_done_in;
    end

    if (|ch_misaligned) begin
      err_d[ERR_MISALIGN] = 1'b1;
    end
    if ((state_q == ST_RUN) && (|wr_req)) begin
      err_d[ERR_NOT_LOADING] = 1'b1;
    end

    // Start fires on the edge where the last done flag latches
    case (state_q)
      ST_IDLE: begin
        if (|wr_req) state_d = ST_LOADING;
      end
      ST_LOADING: begin
        if (&ld_d) begin
          state_d = ST_RUN;
          start_d = 1'b1;
          layer_d = layer_in;
          age_d   = '0;
        end
      end
      ST_RUN: begin
        if (age_q < 2'(RUN_MIN_AGE)) age_d = age_q + 2'd1;
        if (core_ready && (age_q >= 2'(RUN_MIN_AGE))) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (|ch_accept) state_d = ST_LOADING;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_req && (state_q == ST_DONE);
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      age_q     <= '0;
      start_q   <= 1'b0;
      layer_q   <= 1'b0;
      ld_q      <= '0;
      err_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      age_q     <= age_d;
      start_q   <= start_d;
      layer_q   <= layer_d;
      ld_q      <= ld_d;
      err_q     <= err_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign core_start     = start_q;
  assign core_layer     = layer_q;
  assign core_load_done = ld_q;
  assign state_o        = state_q;
  assign err_o          = err_q;

  // The feature BRAM delivers data RD_LATENCY cycles after the address
  assign core_rd_addr   = rd_addr[ADDR_W-1:2];
  assign rd_addr_unused = ^rd_addr[1:0];
  assign rd_valid       = rd_pipe_q[RD_LATENCY-1];
  assign rd_data        = rd_valid ? core_rd_dout : '0;

endmodule

// File: tb/tb_gat_bram_port_adapter.sv
// Directed self-checking bench for gat_bram_port_adapter (default parameters).
module tb_gat_bram_port_adapter;

  localparam int unsigned TW = 32;
  localparam int unsigned NC = 3;
  localparam int unsigned AW = 20;
  localparam int unsigned RL = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NC-1:0]      wr_ena, wr_wea, load_done_in;
  logic [NC*AW-1:0]   wr_addra;
  logic [NC*TW-1:0]   wr_din;
  logic               layer_in, core_ready;
  logic [NC-1:0]      core_ena, core_wea, core_load_done;
  logic [NC*(AW-2)-1:0] core_addra;
  logic [NC*TW-1:0]   core_din;
  logic               core_layer, core_start;
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic [AW-3:0]      core_rd_addr;
  logic [TW-1:0]      core_rd_dout;
  logic               rd_valid;
  logic [TW-1:0]      rd_data;
  logic [1:0]         state_o, err_o;
  logic [NC*AW-1:0]   wr_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gat_bram_port_adapter #(
    .TOP_WIDTH  (TW),
    .NUM_CH     (NC),
    .ADDR_W     (AW),
    .RD_LATENCY (RL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_ena         (wr_ena),
    .wr_wea         (wr_wea),
    .wr_addra       (wr_addra),
    .wr_din         (wr_din),
    .load_done_in   (load_done_in),
    .layer_in       (layer_in),
    .core_ready     (core_ready),
    .core_ena       (core_ena),
    .core_wea       (core_wea),
    .core_addra     (core_addra),
    .core_din       (core_din),
    .core_load_done (core_load_done),
    .core_layer     (core_layer),
    .core_start     (core_start),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .core_rd_addr   (core_rd_addr),
    .core_rd_dout   (core_rd_dout),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .state_o        (state_o),
    .err_o          (err_o),
    .wr_cnt         (wr_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic no_write();
    wr_ena   = '0;
    wr_wea   = '0;
    wr_addra = '0;
    wr_din   = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    no_write();
    load_done_in = '0;
    layer_in     = 1'b0;
    core_ready   = 1'b0;
    rd_req       = 1'b0;
    rd_addr      = '0;
    core_rd_dout = '0;

    // Reset state
    step();
    step();
    check("rst_state", 128'(state_o), 128'd0);
    check("rst_core_ena", 128'(core_ena), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    check("rst_wr_cnt", 128'(wr_cnt), 128'd0);
    check("rst_rd_valid", 128'(rd_valid), 128'd0);
    check("rst_start", 128'(core_start), 128'd0);
    check("rst_load_done", 128'(core_load_done), 128'd0);
    rst_n = 1'b1;
    step();

    // Aligned write ch0 in IDLE
    wr_ena = 3'b001; wr_wea = 3'b001;
    wr_addra[0 +: AW] = 20'h10; wr_din[0 +: TW] = 32'hAB;
    step();
    no_write();
    check("wr0_ena", 128'(core_ena), 128'b001);
    check("wr0_wea", 128'(core_wea), 128'b001);
    check("wr0_addra", 128'(core_addra[0 +: 18]), 128'd4);
    check("wr0_din", 128'(core_din[0 +: TW]), 128'hAB);
    check("wr0_state", 128'(state_o), 128'd1);
    check("wr0_cnt", 128'(wr_cnt[0 +: AW]), 128'd1);
    step();
    check("wr0_ena_drop", 128'(core_ena), 128'd0);

    // Misaligned write ch1
    wr_ena = 3'b010; wr_wea = 3'b010; wr_addra[AW +: AW] = 20'h13;
    step();
    no_write();
    check("mis_ena", 128'(core_ena), 128'd0);
    check("mis_err", 128'(err_o), 128'b01);
    check("mis_cnt1", 128'(wr_cnt[AW +: AW]), 128'd0);

    // Enable without write-enable is not a write
    wr_ena = 3'b001; wr_wea = 3'b000; wr_addra[0 +: AW] = 20'h30;
    step();
    no_write();
    check("nowea_ena", 128'(core_ena), 128'd0);
    check("nowea_cnt0", 128'(wr_cnt[0 +: AW]), 128'd1);

    // Simultaneous writes on all channels
    wr_ena = 3'b111; wr_wea = 3'b111;
    wr_addra = {20'h28, 20'h24, 20'h20};
    wr_din   = {32'h33, 32'h22, 32'h11};
    step();
    no_write();
    check("all_ena", 128'(core_ena), 128'b111);
    check("all_addra", 128'(core_addra), 128'({18'd10, 18'd9, 18'd8}));
    check("all_din", 128'(core_din), 128'({32'h33, 32'h22, 32'h11}));
    check("all_cnt", 128'(wr_cnt), 128'({20'd1, 20'd1, 20'd2}));

    // All channels loaded -> start
    load_done_in = 3'b111; layer_in = 1'b1;
    step();
    load_done_in = '0; layer_in = 1'b0;
    check("start_pulse", 128'(core_start), 128'd1);
    check("start_state", 128'(state_o), 128'd2);
    check("start_layer", 128'(core_layer), 128'd1);
    check("start_ld", 128'(core_load_done), 128'b111);

    // core_ready too early is ignored
    core_ready = 1'b1;
    step();
    check("start_single", 128'(core_start), 128'd0);
    check("early_rdy0", 128'(state_o), 128'd2);
    step();
    check("early_rdy1", 128'(state_o), 128'd2);
    check("layer_hold", 128'(core_layer), 128'd1);
    core_ready = 1'b0;

    // Write in RUN is dropped
    wr_ena = 3'b100; wr_wea = 3'b100; wr_addra[2*AW +: AW] = 20'h40;
    step();
    no_write();
    check("run_wr_ena", 128'(core_ena), 128'd0);
    check("run_wr_err", 128'(err_o), 128'b11);
    check("run_wr_cnt2", 128'(wr_cnt[2*AW +: AW]), 128'd1);
    check("run_state", 128'(state_o), 128'd2);

    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    check("done_state", 128'(state_o), 128'd3);

    // Pipelined reads in DONE
    rd_req = 1'b1; rd_addr = 20'h0; core_rd_dout = 32'hD0; #1;
    check("rd0_addr", 128'(core_rd_addr), 128'd0);
    check("rd0_valid", 128'(rd_valid), 128'd0);
    step();
    rd_addr = 20'h4; core_rd_dout = 32'hD1; #1;
    check("rd1_addr", 128'(core_rd_addr), 128'd1);
    check("rd1_valid", 128'(rd_valid), 128'd0);
    step();
    rd_addr = 20'h8; core_rd_dout = 32'hD2; #1;
    check("rd2_addr", 128'(core_rd_addr), 128'd2);
    check("rd2_valid", 128'(rd_valid), 128'd1);
    check("rd2_data", 128'(rd_data), 128'hD2);
    step();
    rd_req = 1'b0; core_rd_dout = 32'hD3; #1;
    check("rd3_valid", 128'(rd_valid), 128'd1);
    check("rd3_data", 128'(rd_data), 128'hD3);
    step();
    core_rd_dout = 32'hD4; #1;
    check("rd4_valid", 128'(rd_valid), 128'd1);
    check("rd4_data", 128'(rd_data), 128'hD4);
    step();
    check("rd5_valid", 128'(rd_valid), 128'd0);
    check("rd5_data", 128'(rd_data), 128'd0);

    // Write in DONE reloads; read issued alongside still completes
    wr_ena = 3'b010; wr_wea = 3'b010;
    wr_addra[AW +: AW] = 20'h8; wr_din[TW +: TW] = 32'h55;
    rd_req = 1'b1; rd_addr = 20'hC;
    step();
    no_write();
    check("reload_state", 128'(state_o), 128'd1);
    check("reload_ld", 128'(core_load_done), 128'd0);
    check("reload_cnt", 128'(wr_cnt), 128'({20'd0, 20'd1, 20'd0}));
    check("reload_ena", 128'(core_ena), 128'b010);
    check("reload_addra", 128'(core_addra[18 +: 18]), 128'd2);
    check("reload_rdv0", 128'(rd_valid), 128'd0);
    step();
    rd_req = 1'b0;
    core_rd_dout = 32'hE1; #1;
    check("flight_rdv", 128'(rd_valid), 128'd1);
    check("flight_data", 128'(rd_data), 128'hE1);
    step();
    check("loading_rd_ignored", 128'(rd_valid), 128'd0);

    // Back to DONE for the reset-abort scenario
    load_done_in = 3'b111;
    step();
    load_done_in = '0;
    check("run2_state", 128'(state_o), 128'd2);
    step();
    step();
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    check("done2_state", 128'(state_o), 128'd3);

    wr_ena = 3'b100; wr_wea = 3'b100;
    wr_addra[2*AW +: AW] = 20'h14; wr_din[2*TW +: TW] = 32'h77;
    rd_req = 1'b1; rd_addr = 20'h10;
    step();
    no_write();
    rd_req = 1'b0;
    check("abort_wr_landed", 128'(core_ena), 128'b100);
    rst_n = 1'b0;
    core_rd_dout = 32'hF0;
    step();
    check("abort_state", 128'(state_o), 128'd0);
    check("abort_rd_valid", 128'(rd_valid), 128'd0);
    check("abort_rd_data", 128'(rd_data), 128'd0);
    check("abort_core_ena", 128'(core_ena), 128'd0);
    check("abort_core_wea", 128'(core_wea), 128'd0);
    check("abort_addra", 128'(core_addra), 128'd0);
    check("abort_din", 128'(core_din), 128'd0);
    check("abort_ld", 128'(core_load_done), 128'd0);
    check("abort_layer", 128'(core_layer), 128'd0);
    check("abort_start", 128'(core_start), 128'd0);
    check("abort_err", 128'(err_o), 128'd0);
    check("abort_cnt", 128'(wr_cnt), 128'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_rdv", 128'(rd_valid), 128'd0);
    check("post_rst_ena", 128'(core_ena), 128'd0);
    step();
    check("post_rst_rdv2", 128'(rd_valid), 128'd0);
    check("post_rst_state", 128'(state_o), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
